id_ex_pipe: RTL and testbench

Decode-to-execute pipeline stage directly upstream of the ALU. Captures decoded instruction fields and selects ALU operands: a is rs1 data or PC, b is rs2 data or the immediate. Presents alu_ctr, a and b to the ALU with registered timing. A 2-entry skid buffer with a valid/ready handshake lets execute stall without a combinational ready path back to decode. Flush support handles branches and jumps.

---
 rtl/id_ex_pipe.sv | 174 +++++++++++++++++
 tb/tb_id_ex_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX stage: selects and registers the ALU operands behind a 2-entry skid buffer.
// Build option FWD_EN: result forwarding into the captured and held rs1/rs2 operands.
module id_ex_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [3:0]        in_alu_ctr,
  input  logic              in_a_sel,
  input  logic              in_b_sel,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_wen,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_ctr,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_wen
);

  typedef struct packed {
    logic [3:0]        alu_ctr;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rd;
    logic              reg_wen;
`ifdef FWD_EN
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              a_sel;
    logic              b_sel;
`endif
  } entry_t;

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  entry_t main_held, skid_held;
  logic   accept, advance;
  logic [XLEN-1:0] rs1_eff, rs2_eff;

`ifdef FWD_EN
  // Register 0 is hardwired, so a writer targeting rd=0 never forwards.
  function automatic logic fwd_hit(input logic              v,
                                   input logic [REG_AW-1:0] frd,
                                   input logic [REG_AW-1:0] idx);
    return v && (frd != '0) && (frd == idx);
  endfunction

  function automatic entry_t snoop(input entry_t            e,
                                   input logic              v,
                                   input logic [REG_AW-1:0] frd,
                                   input logic [XLEN-1:0]   fd);
    entry_t r;
    r = e;
    if (fwd_hit(v, frd, e.rs1) && !e.a_sel) r.a = fd;
    if (fwd_hit(v, frd, e.rs2)) begin
      r.rs2_data = fd;
      if (!e.b_sel) r.b = fd;
    end
    return r;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};
`endif

  always_comb begin
    rs1_eff = in_rs1_data;
    rs2_eff = in_rs2_data;
`ifdef FWD_EN
    if (fwd_hit(fwd_valid, fwd_rd, in_rs1)) rs1_eff = fwd_data;
    if (fwd_hit(fwd_valid, fwd_rd, in_rs2)) rs2_eff = fwd_data;
`endif
    in_entry          = '0;
    in_entry.alu_ctr  = in_alu_ctr;
    in_entry.a        = in_a_sel ? in_pc : rs1_eff;
    in_entry.b        = in_b_sel ? in_imm : rs2_eff;
    in_entry.pc       = in_pc;
    in_entry.rs2_data = rs2_eff;
    in_entry.rd       = in_rd;
    in_entry.reg_wen  = in_reg_wen;
`ifdef FWD_EN
    in_entry.rs1      = in_rs1;
    in_entry.rs2      = in_rs2;
    in_entry.a_sel    = in_a_sel;
    in_entry.b_sel    = in_b_sel;
`endif
  end

`ifdef FWD_EN
  assign main_held = snoop(main_q, fwd_valid, fwd_rd, fwd_data);
  assign skid_held = snoop(skid_q, fwd_valid, fwd_rd, fwd_data);
`else
  assign main_held = main_q;
  assign skid_held = skid_q;
`endif

  assign accept  = in_valid & in_ready_q;
  assign advance = ~main_valid_q | out_ready;

  // in_ready_q mirrors ~skid_valid_q, so the skid is never written while it is full.
  always_comb begin
    main_d       = main_held;
    skid_d       = skid_held;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (advance) begin
      if (skid_valid_q) begin
        main_d       = skid_held;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_entry;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign alu_ctr      = main_q.alu_ctr;
  assign a            = main_q.a;
  assign b            = main_q.b;
  assign out_pc       = main_q.pc;
  assign out_rs2_data = main_q.rs2_data;
  assign out_rd       = main_q.rd;
  assign out_reg_wen  = main_q.reg_wen;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed vector bench for id_ex_pipe: table of cycle vectors plus reset/forwarding sequences.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [3:0]  in_alu_ctr;
  logic        in_a_sel, in_b_sel;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_reg_wen;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctr;
  logic [31:0] a, b, out_pc, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_reg_wen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alu_ctr(in_alu_ctr), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_reg_wen(in_reg_wen),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctr(alu_ctr), .a(a), .b(b), .out_pc(out_pc), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_reg_wen(out_reg_wen)
  );

  typedef struct {
    logic        iv, fl, orr;
    int          id;
    logic        as, bs;
    logic        ov, ir;
    int          eid;
    logic [31:0] ea, eb;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic iv, input logic fl, input logic orr,
                              input int id, input logic as, input logic bs,
                              input logic ov, input logic ir, input int eid,
                              input logic [31:0] ea, input logic [31:0] eb);
    row_t r;
    r.iv = iv; r.fl = fl; r.orr = orr; r.id = id; r.as = as; r.bs = bs;
    r.ov = ov; r.ir = ir; r.eid = eid; r.ea = ea; r.eb = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Beat k: pc=0x100+16k, rs1=0xA00+k, rs2=0xB00+k, imm=0xC00+k, alu=k[3:0], rd=k[4:0], wen=k[0].
  task automatic drive_beat(input int id, input logic as, input logic bs);
    in_pc       = 32'h100 + id * 16;
    in_rs1_data = 32'hA00 + id;
    in_rs2_data = 32'hB00 + id;
    in_imm      = 32'hC00 + id;
    in_alu_ctr  = id[3:0];
    in_rd       = id[4:0];
    in_reg_wen  = id[0];
    in_a_sel    = as;
    in_b_sel    = bs;
    in_rs1      = 5'd1;
    in_rs2      = 5'd2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    row_t r;
    int   eid;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    in_valid = 1'b1;
    drive_beat(3, 1'b0, 1'b0);
    tick; tick;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_a", a, 32'd0);
    chk("reset_b", b, 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    $display("reset: out_valid=%0b in_ready=%0b a=%h b=%h", out_valid, in_ready, a, b);

    // First beat after release
    in_pc = 32'h100; in_imm = 32'd4; in_alu_ctr = 4'd0; in_a_sel = 1'b1; in_b_sel = 1'b1;
    in_rd = 5'd3; in_reg_wen = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("first_out_valid", {31'b0, out_valid}, 32'd1);
    chk("first_a", a, 32'h100);
    chk("first_b", b, 32'd4);
    chk("first_alu", {28'b0, alu_ctr}, 32'd0);
    chk("first_rd", {27'b0, out_rd}, 32'd3);
    $display("first beat: out_valid=%0b a=%h b=%h", out_valid, a, b);

    //          iv  fl  or  id  as  bs  ov  ir  eid  a        b
    rows.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 1, 32'hA01, 32'hB01));
    rows.push_back(mk(1, 0, 1, 2, 1, 0, 1, 1, 2, 32'h120, 32'hB02));
    rows.push_back(mk(1, 0, 1, 3, 0, 1, 1, 1, 3, 32'hA03, 32'hC03));
    rows.push_back(mk(1, 0, 1, 4, 1, 1, 1, 1, 4, 32'h140, 32'hC04));
    rows.push_back(mk(1, 0, 1, 5, 0, 0, 1, 1, 5, 32'hA05, 32'hB05));
    rows.push_back(mk(1, 0, 1, 6, 1, 0, 1, 1, 6, 32'h160, 32'hB06));
    rows.push_back(mk(1, 0, 1, 7, 0, 1, 1, 1, 7, 32'hA07, 32'hC07));
    rows.push_back(mk(1, 0, 1, 8, 1, 1, 1, 1, 8, 32'h180, 32'hC08));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    // stall: X=9 in main, Y=10 in skid, Z=11 held upstream
    rows.push_back(mk(1, 0, 0, 9, 0, 0, 1, 1, 9, 32'hA09, 32'hB09));
    rows.push_back(mk(1, 0, 0, 10, 1, 1, 1, 0, 9, 32'hA09, 32'hB09));
    rows.push_back(mk(1, 0, 0, 11, 0, 1, 1, 0, 9, 32'hA09, 32'hB09));
    rows.push_back(mk(1, 0, 0, 11, 0, 1, 1, 0, 9, 32'hA09, 32'hB09));
    rows.push_back(mk(1, 0, 1, 11, 0, 1, 1, 1, 10, 32'h1A0, 32'hC0A));
    rows.push_back(mk(1, 0, 1, 11, 0, 1, 1, 1, 11, 32'hA0B, 32'hC0B));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    // flush with both entries full and a beat offered
    rows.push_back(mk(1, 0, 0, 12, 0, 0, 1, 1, 12, 32'hA0C, 32'hB0C));
    rows.push_back(mk(1, 0, 0, 13, 1, 0, 1, 0, 12, 32'hA0C, 32'hB0C));
    rows.push_back(mk(1, 1, 0, 14, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    // flush while empty: beat accepted then discarded
    rows.push_back(mk(1, 1, 1, 15, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));
    rows.push_back(mk(1, 0, 1, 16, 0, 0, 1, 1, 16, 32'hA10, 32'hB10));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0));

    for (int i = 0; i < rows.size(); i++) begin
      r = rows[i];
      in_valid = r.iv; flush = r.fl; out_ready = r.orr;
      drive_beat(r.id, r.as, r.bs);
      tick;
      eid = r.eid;
      chk($sformatf("row%0d_out_valid", i), {31'b0, out_valid}, {31'b0, r.ov});
      chk($sformatf("row%0d_in_ready", i), {31'b0, in_ready}, {31'b0, r.ir});
      if (r.ov) begin
        chk($sformatf("row%0d_a", i), a, r.ea);
        chk($sformatf("row%0d_b", i), b, r.eb);
        chk($sformatf("row%0d_alu", i), {28'b0, alu_ctr}, {28'b0, eid[3:0]});
        chk($sformatf("row%0d_pc", i), out_pc, 32'h100 + eid * 16);
        chk($sformatf("row%0d_rs2", i), out_rs2_data, 32'hB00 + eid);
        chk($sformatf("row%0d_rd", i), {27'b0, out_rd}, {27'b0, eid[4:0]});
        chk($sformatf("row%0d_wen", i), {31'b0, out_reg_wen}, {31'b0, eid[0]});
      end
      $display("row %0d: iv=%0b fl=%0b or=%0b id=%0d -> out_valid=%0b in_ready=%0b a=%h b=%h pc=%h",
               i, r.iv, r.fl, r.orr, r.id, out_valid, in_ready, a, b, out_pc);
    end

    // Reset asserted while both entries are occupied
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    drive_beat(20, 0, 0);
    tick;
    drive_beat(21, 0, 0);
    tick;
    chk("prerst_in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_a", a, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("postrst_out_valid", {31'b0, out_valid}, 32'd0);
    $display("reset mid-stall: out_valid=%0b in_ready=%0b", out_valid, in_ready);

`ifdef FWD_EN
    // Capture-time forwarding on rs1
    in_valid = 1'b1; out_ready = 1'b1;
    drive_beat(1, 0, 0);
    in_rs1 = 5'd5; in_rs1_data = 32'h11; in_rs2 = 5'd3; in_rs2_data = 32'h33;
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hAA;
    tick;
    chk("fwd_cap_a", a, 32'hAA);
    chk("fwd_cap_b", b, 32'h33);
    $display("fwd capture: a=%h b=%h", a, b);
    // rd=0 never forwards
    in_rs1 = 5'd0; in_rs1_data = 32'h22; fwd_rd = 5'd0;
    tick;
    chk("fwd_zero_a", a, 32'h22);
    $display("fwd rd0: a=%h", a);
    in_valid = 1'b0; fwd_valid = 1'b0;
    tick;
    // Snoop into a stalled main entry via rs2
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd7; in_b_sel = 1'b0; in_rs2_data = 32'h33;
    tick;
    chk("fwd_pre_b", b, 32'h33);
    in_valid = 1'b0; out_ready = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd7; fwd_data = 32'h55;
    tick;
    fwd_valid = 1'b0;
    chk("fwd_snoop_valid", {31'b0, out_valid}, 32'd1);
    chk("fwd_snoop_b", b, 32'h55);
    chk("fwd_snoop_rs2", out_rs2_data, 32'h55);
    $display("fwd snoop: b=%h rs2_data=%h", b, out_rs2_data);
    out_ready = 1'b1;
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
